// File: rtl/frame_parser.sv
// UART byte-stream frame parser: 4-byte little-endian size header followed by
// width*height pixels, tagged with sof/eol/eof and buffered in a FWFT FIFO.
module frame_parser #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_DIM    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [7:0]  pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] img_width,
  output logic [15:0] img_height,
  output logic        hdr_valid,
  output logic        hdr_err,
  output logic        overflow
);

  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW        = AW + 1;
  localparam logic [15:0] MAX_DIM_W = 16'(MAX_DIM);

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } entry_t;

  typedef enum logic {S_HDR = 1'b0, S_PIX = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    hdr_cnt_q;
  logic [7:0]    w_lo_q, w_hi_q, h_lo_q;
  logic [15:0]   col_q, row_q;
  logic [15:0]   hdr_w, hdr_h;
  logic          dims_ok;
  logic          hdr_accept, hdr_reject, pix_wr;
  entry_t        wr_entry, rd_entry;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, rd_en, wr_en;

  // Candidate dimensions as seen while the 4th header byte is on rx_data
  assign hdr_w   = {w_hi_q, w_lo_q};
  assign hdr_h   = {rx_data, h_lo_q};
  assign dims_ok = (hdr_w != 16'd0) && (hdr_w <= MAX_DIM_W) &&
                   (hdr_h != 16'd0) && (hdr_h <= MAX_DIM_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HDR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: if (rx_valid && !rx_err && (hdr_cnt_q == 2'd3) && dims_ok) state_d = S_PIX;
      S_PIX: if (rx_valid && wr_entry.eof) state_d = S_HDR;
    endcase
  end

  always_comb begin
    hdr_accept    = 1'b0;
    hdr_reject    = 1'b0;
    pix_wr        = 1'b0;
    wr_entry.data = rx_data;
    wr_entry.sof  = (row_q == 16'd0) && (col_q == 16'd0);
    wr_entry.eol  = (col_q == img_width - 16'd1);
    wr_entry.eof  = wr_entry.eol && (row_q == img_height - 16'd1);
    case (state_q)
      S_HDR: begin
        if (rx_valid) begin
          if (rx_err)                      hdr_reject = 1'b1;
          else if (hdr_cnt_q == 2'd3) begin
            if (dims_ok) hdr_accept = 1'b1;
            else         hdr_reject = 1'b1;
          end
        end
      end
      S_PIX: pix_wr = rx_valid;
    endcase
  end

  // Header capture, frame geometry and stream position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_q  <= 2'd0;
      w_lo_q     <= 8'd0;
      w_hi_q     <= 8'd0;
      h_lo_q     <= 8'd0;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      img_width  <= 16'd0;
      img_height <= 16'd0;
      hdr_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      hdr_valid <= hdr_accept;
      hdr_err   <= hdr_reject;
      if (state_q == S_HDR && rx_valid) begin
        if (rx_err || hdr_cnt_q == 2'd3) hdr_cnt_q <= 2'd0;
        else                             hdr_cnt_q <= hdr_cnt_q + 2'd1;
        if (!rx_err) begin
          case (hdr_cnt_q)
            2'd0:    w_lo_q <= rx_data;
            2'd1:    w_hi_q <= rx_data;
            2'd2:    h_lo_q <= rx_data;
            default: ;
          endcase
        end
      end
      if (hdr_accept) begin
        img_width  <= hdr_w;
        img_height <= hdr_h;
        col_q      <= 16'd0;
        row_q      <= 16'd0;
        overflow   <= 1'b0;
      end
      // Position advances even when the FIFO drops the byte
      if (pix_wr) begin
        if (wr_entry.eof) begin
          col_q <= 16'd0;
          row_q <= 16'd0;
        end else if (wr_entry.eol) begin
          col_q <= 16'd0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
      if (pix_wr && fifo_full && !rd_en) overflow <= 1'b1;
    end
  end

  assign pix_valid = (count_q != CW'(0));
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign rd_en     = pix_valid && pix_ready;
  assign wr_en     = pix_wr && (!fifo_full || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_entry;
  end

  // Head entry is masked to zero while empty so stale storage never shows
  assign rd_entry = pix_valid ? mem[rd_ptr_q] : '0;
  assign pix_data = rd_entry.data;
  assign pix_sof  = rd_entry.sof;
  assign pix_eol  = rd_entry.eol;
  assign pix_eof  = rd_entry.eof;

endmodule

// File: tb/tb_frame_parser.sv
// Self-checking bench for frame_parser: header/frame vector table, directed
// FIFO-full and reset sequences, and randomized frames against a pixel model.
module tb_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_err;
  logic [7:0]  pix_data;
  logic        pix_sof, pix_eol, pix_eof, pix_valid, pix_ready;
  logic [15:0] img_width, img_height;
  logic        hdr_valid, hdr_err, overflow;

  frame_parser #(.FIFO_DEPTH(16), .MAX_DIM(1024)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .img_width(img_width),
    .img_height(img_height), .hdr_valid(hdr_valid), .hdr_err(hdr_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef struct {
    string      name;
    logic [7:0] b0, b1, b2, b3;
    int         err_pos;
    bit         ok;
    int         w, h;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   hv_cnt = 0;
  int   he_cnt = 0;
  int   last_w = 0;
  int   last_h = 0;
  pix_t got[$];
  pix_t exp_q[$];
  vec_t vecs[$];
  bit   hold_valid = 1'b0;
  pix_t hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference pixel: position k of a w x h frame, raster order
  function automatic pix_t model(input int k, input int w, input int h, input logic [7:0] d);
    pix_t p;
    p.d   = d;
    p.sof = (k == 0);
    p.eol = ((k % w) == w - 1);
    p.eof = (k == w * h - 1);
    return p;
  endfunction

  // Transfer monitor and stall-stability check, sampled mid-cycle
  always @(negedge clk) begin
    pix_t cur;
    cur = {pix_data, pix_sof, pix_eol, pix_eof};
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) check("stall_hold", 32'({pix_valid, cur}), 32'({1'b1, hold}));
      if (hdr_valid) hv_cnt++;
      if (hdr_err)   he_cnt++;
      if (pix_valid && pix_ready) got.push_back(cur);
      hold_valid = pix_valid && !pix_ready;
      hold       = cur;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_err   = e;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic hdr_test(input string name, input logic [7:0] b0, b1, b2, b3,
                          input int err_pos, input bit ok, input int w, input int h);
    logic [7:0] hb [4];
    int hv0, he0;
    hb[0] = b0; hb[1] = b1; hb[2] = b2; hb[3] = b3;
    hv0 = hv_cnt;
    he0 = he_cnt;
    for (int i = 0; i < 4; i++) begin
      send_byte(hb[i], i == err_pos);
      if (i == err_pos) break;
    end
    idle(1);
    if (ok) begin
      last_w = w;
      last_h = h;
    end
    check({name, "_hv"}, 32'(hv_cnt - hv0), 32'(ok));
    check({name, "_he"}, 32'(he_cnt - he0), 32'(!ok));
    check({name, "_w"},  32'(img_width),  32'(last_w));
    check({name, "_h"},  32'(img_height), 32'(last_h));
  endtask

  task automatic send_pixels(input int k0, input int n, input int w, input int h,
                             input bit rnd, input bit keep);
    logic [7:0] d;
    logic       e;
    for (int k = k0; k < k0 + n; k++) begin
      d = 8'($urandom);
      e = ($urandom % 8) == 0;
      if (rnd) pix_ready = 1'($urandom % 2);
      send_byte(d, e);
      if (keep) exp_q.push_back(model(k, w, h, d));
      if (rnd) begin
        pix_ready = 1'b1;
        idle(1 + ($urandom % 2));
      end
    end
  endtask

  task automatic compare_stream(input string name, input int base);
    int waited = 0;
    while ((got.size() - base) < exp_q.size() && waited < 3000) begin
      idle(1);
      waited++;
    end
    idle(3);
    check({name, "_n"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (base + i) < got.size(); i++) begin
      check({name, "_px"}, 32'(got[base + i]), 32'(exp_q[i]));
      if (got[base + i] !== exp_q[i]) break;
    end
    exp_q.delete();
  endtask

  initial begin
    int base;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; rx_err = 1'b0; pix_ready = 1'b1;
    #12;
    check("reset_pix",   32'({pix_valid, pix_data, pix_sof, pix_eol, pix_eof}), 32'd0);
    check("reset_dims",  32'({img_width, img_height}), 32'd0);
    check("reset_flags", 32'({hdr_valid, hdr_err, overflow}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    vecs.push_back('{"f5x7",    8'd5,  8'd0,  8'd7, 8'd0, -1, 1'b1, 5, 7});
    vecs.push_back('{"w0",      8'd0,  8'd0,  8'd7, 8'd0, -1, 1'b0, 0, 0});
    vecs.push_back('{"f2x2",    8'd2,  8'd0,  8'd2, 8'd0, -1, 1'b1, 2, 2});
    vecs.push_back('{"err3",    8'd5,  8'd0,  8'd7, 8'd0,  2, 1'b0, 0, 0});
    vecs.push_back('{"f5x7b",   8'd5,  8'd0,  8'd7, 8'd0, -1, 1'b1, 5, 7});
    vecs.push_back('{"f1x1",    8'd1,  8'd0,  8'd1, 8'd0, -1, 1'b1, 1, 1});
    vecs.push_back('{"f1x4",    8'd1,  8'd0,  8'd4, 8'd0, -1, 1'b1, 1, 4});
    vecs.push_back('{"f6x1",    8'd6,  8'd0,  8'd1, 8'd0, -1, 1'b1, 6, 1});
    vecs.push_back('{"w1025",   8'd1,  8'd4,  8'd1, 8'd0, -1, 1'b0, 0, 0});
    vecs.push_back('{"h1025",   8'd1,  8'd0,  8'd1, 8'd4, -1, 1'b0, 0, 0});
    vecs.push_back('{"h0",      8'd3,  8'd0,  8'd0, 8'd0, -1, 1'b0, 0, 0});
    vecs.push_back('{"w4660",   8'h34, 8'h12, 8'd1, 8'd0, -1, 1'b0, 0, 0});
    vecs.push_back('{"err4",    8'd2,  8'd0,  8'd2, 8'd0,  3, 1'b0, 0, 0});
    vecs.push_back('{"f1024x1", 8'd0,  8'd4,  8'd1, 8'd0, -1, 1'b1, 1024, 1});
    vecs.push_back('{"f1x1024", 8'd1,  8'd0,  8'd0, 8'd4, -1, 1'b1, 1, 1024});

    foreach (vecs[i]) begin
      hdr_test(vecs[i].name, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3,
               vecs[i].err_pos, vecs[i].ok, vecs[i].w, vecs[i].h);
      if (vecs[i].ok) begin
        base = got.size();
        send_pixels(0, vecs[i].w * vecs[i].h, vecs[i].w, vecs[i].h, 1'b0, 1'b1);
        compare_stream(vecs[i].name, base);
      end
    end

    // Fill past capacity with the consumer stalled
    pix_ready = 1'b0;
    hdr_test("ovf_hdr", 8'd4, 8'd0, 8'd8, 8'd0, -1, 1'b1, 4, 8);
    base = got.size();
    send_pixels(0, 16, 4, 8, 1'b0, 1'b1);
    idle(1);
    check("ovf_exact_fit", 32'(overflow), 32'd0);
    send_pixels(16, 4, 4, 8, 1'b0, 1'b0);
    idle(1);
    check("ovf_valid", 32'(pix_valid), 32'd1);
    check("ovf_set",   32'(overflow), 32'd1);
    pix_ready = 1'b1;
    compare_stream("ovf_drain", base);
    base = got.size();
    send_pixels(20, 12, 4, 8, 1'b0, 1'b1);
    compare_stream("ovf_tail", base);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous read and write on a full FIFO
    pix_ready = 1'b0;
    hdr_test("full_hdr", 8'd4, 8'd0, 8'd8, 8'd0, -1, 1'b1, 4, 8);
    check("full_ovf_clr", 32'(overflow), 32'd0);
    base = got.size();
    send_pixels(0, 16, 4, 8, 1'b0, 1'b1);
    idle(1);
    check("full_valid", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    send_pixels(16, 1, 4, 8, 1'b0, 1'b1);
    pix_ready = 1'b0;
    idle(1);
    check("full_rw_no_ovf", 32'(overflow), 32'd0);
    send_pixels(17, 1, 4, 8, 1'b0, 1'b0);
    idle(1);
    check("full_still16", 32'(overflow), 32'd1);
    pix_ready = 1'b1;
    compare_stream("full_drain", base);
    base = got.size();
    send_pixels(18, 14, 4, 8, 1'b0, 1'b1);
    compare_stream("full_tail", base);

    // Randomized frames, bad headers and consumer stalls
    base = got.size();
    for (int f = 0; f < 30; f++) begin
      if (($urandom % 5) == 0) begin
        int kind = $urandom % 4;
        int bw = 3, bh = 3, ep = -1;
        if (kind == 0) bw = 0;
        if (kind == 1) bw = 1025 + ($urandom % 100);
        if (kind == 2) bh = 0;
        if (kind == 3) ep = $urandom % 4;
        hdr_test("rnd_bad", 8'(bw), 8'(bw >> 8), 8'(bh), 8'(bh >> 8), ep, 1'b0, 0, 0);
      end else begin
        int w = 1 + ($urandom % 6);
        int h = 1 + ($urandom % 4);
        hdr_test("rnd_hdr", 8'(w), 8'd0, 8'(h), 8'd0, -1, 1'b1, w, h);
        send_pixels(0, w * h, w, h, 1'b1, 1'b1);
      end
    end
    compare_stream("rnd", base);
    check("rnd_no_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a frame
    hdr_test("rst_hdr", 8'd5, 8'd0, 8'd7, 8'd0, -1, 1'b1, 5, 7);
    send_pixels(0, 10, 5, 7, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_pix",   32'({pix_valid, pix_data, pix_sof, pix_eol, pix_eof}), 32'd0);
    check("rst_dims",  32'({img_width, img_height}), 32'd0);
    check("rst_flags", 32'({hdr_valid, hdr_err, overflow}), 32'd0);
    idle(1);
    rst = 1'b0;
    last_w = 0;
    last_h = 0;
    idle(1);
    base = got.size();
    hdr_test("rst_1x1", 8'd1, 8'd0, 8'd1, 8'd0, -1, 1'b1, 1, 1);
    send_byte(8'hFF, 1'b0);
    exp_q.push_back(pix_t'{8'hFF, 1'b1, 1'b1, 1'b1});
    compare_stream("rst_px", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
